// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between committed stores and loads.
// One access at a time; the port is held from grant until the cache responds.
module dcache_port_arbiter #(
  parameter int TAG_W      = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             st_req,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic [3:0]       st_byte_en,
  output logic             st_resp,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             ld_resp,
  output logic [31:0]      ld_rdata,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic             dc_read,
  output logic             dc_write,
  output logic [31:0]      dc_address,
  output logic [31:0]      dc_wdata,
  output logic [3:0]       dc_byte_enable,
  input  logic [31:0]      dc_rdata,
  input  logic             dc_resp
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    starve_q, starve_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic st_grant, ld_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      tag_q    <= tag_d;
    end
  end

  // A waiting load wins once stores have taken STARVE_MAX grants in a row.
  assign st_grant = (state_q == IDLE) && st_req && !(ld_req && (starve_q == STARVE_LIM));
  assign ld_grant = (state_q == IDLE) && !st_grant && ld_req && !flush;

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    tag_d          = tag_q;
    st_resp        = 1'b0;
    ld_resp        = 1'b0;
    ld_rdata       = '0;
    ld_resp_tag    = tag_q;
    dc_read        = 1'b0;
    dc_write       = 1'b0;
    dc_address     = '0;
    dc_wdata       = '0;
    dc_byte_enable = '0;

    unique case (state_q)
      IDLE: begin
        if (st_grant) begin
          state_d = STORE;
          addr_d  = st_addr;
          wdata_d = st_wdata;
          be_d    = st_byte_en;
          if (!ld_req)
            starve_d = '0;
          else if (starve_q != STARVE_LIM)
            starve_d = starve_q + CW'(1);
        end else if (ld_grant) begin
          state_d  = LOAD;
          addr_d   = ld_addr;
          wdata_d  = '0;
          be_d     = 4'hF;
          tag_d    = ld_tag;
          starve_d = '0;
        end else if (!ld_req) begin
          starve_d = '0;
        end
      end
      STORE: begin
        dc_write       = 1'b1;
        dc_address     = addr_q & ~32'h3;
        dc_wdata       = wdata_q;
        dc_byte_enable = be_q;
        st_resp        = dc_resp;
        if (dc_resp) state_d = IDLE;
      end
      LOAD: begin
        dc_read        = 1'b1;
        dc_address     = addr_q & ~32'h3;
        dc_byte_enable = 4'hF;
        ld_resp        = dc_resp && !flush;
        ld_rdata       = ld_resp ? dc_rdata : '0;
        if (dc_resp)    state_d = IDLE;
        else if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        // Flushed load: keep the handshake alive but swallow the data.
        dc_read        = 1'b1;
        dc_address     = addr_q & ~32'h3;
        dc_byte_enable = 4'hF;
        if (dc_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
